// File: rtl/trigger_engine_pkg.sv
// Shared types for the ADC trigger engine: mode encodings, FSM states and
// a lowest-set-bit helper used for sub-word trigger phase reporting.
package trigger_pkg;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'd0,
    TRIG_RISING    = 2'd1,
    TRIG_FALLING   = 2'd2,
    TRIG_EXTERNAL  = 2'd3
  } trig_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    FIRE,
    CAPTURE
  } state_e;

  localparam int unsigned MAX_SAMP = 64;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [7:0] first_set(input logic [MAX_SAMP-1:0] v);
    first_set = '0;
    for (int unsigned i = MAX_SAMP; i > 0; i--) begin
      if (v[i-1]) first_set = 8'(i - 1);
    end
  endfunction

endpackage

// File: rtl/trigger_engine_if.sv
// Sample stream in from the deserialiser and write port out to the capture FIFO.
interface trigger_engine_if #(
  parameter int unsigned NCH   = 1,
  parameter int unsigned NSAMP = 10,
  parameter int unsigned SW    = 12
);
  localparam int unsigned WW = NCH * NSAMP * SW;

  logic [WW-1:0] samples;
  logic          samples_valid;
  logic          fifo_full;
  logic          wr_en;
  logic [WW-1:0] wr_data;

  modport master (
    output samples, samples_valid, fifo_full,
    input  wr_en, wr_data
  );

  modport slave (
    input  samples, samples_valid, fifo_full,
    output wr_en, wr_data
  );
endinterface

// File: rtl/trigger_engine_sample_compare.sv
// Parallel signed threshold compare of one channel word against lower/upper,
// reporting whether any sample crosses and the oldest crossing index.
module sample_compare
  import trigger_pkg::*;
#(
  parameter int unsigned NSAMP = 10,
  parameter int unsigned SW    = 12,
  parameter int unsigned PW    = 4
) (
  input  logic [NSAMP*SW-1:0] word,
  input  logic signed [SW-1:0] lower,
  input  logic signed [SW-1:0] upper,
  output logic                 any_below,
  output logic                 any_above,
  output logic [PW-1:0]        first_below_idx,
  output logic [PW-1:0]        first_above_idx
);
  logic [MAX_SAMP-1:0] below;
  logic [MAX_SAMP-1:0] above;

  always_comb begin
    below = '0;
    above = '0;
    for (int unsigned j = 0; j < NSAMP; j++) begin
      below[j] = $signed(word[j*SW +: SW]) < lower;
      above[j] = $signed(word[j*SW +: SW]) > upper;
    end
    any_below       = |below;
    any_above       = |above;
    first_below_idx = PW'(first_set(below));
    first_above_idx = PW'(first_set(above));
  end
endmodule

// File: rtl/trigger_engine.sv
// Acquisition/trigger engine: arms on request, detects a threshold crossing,
// external or timed-out trigger, then streams a fixed word count to the FIFO.
module trigger_engine
  import trigger_pkg::*;
#(
  parameter int unsigned NCH   = 1,
  parameter int unsigned NSAMP = 10,
  parameter int unsigned SW    = 12,
  parameter int unsigned CNTW  = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  trigger_engine_if.slave                              bus,
  input  logic                                         arm,
  input  logic                                         abort,
  input  logic [1:0]                                   cfg_mode,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]     cfg_chan,
  input  logic signed [SW-1:0]                         cfg_lower,
  input  logic signed [SW-1:0]                         cfg_upper,
  input  logic [CNTW-1:0]                              cfg_length,
  input  logic [CNTW-1:0]                              cfg_timeout,
  input  logic                                         ext_trig,
  output logic                                         busy,
  output logic                                         done,
  output logic [((NSAMP > 1) ? $clog2(NSAMP) : 1)-1:0] trig_phase,
  output logic                                         trig_forced,
  output logic                                         overflow,
  output logic [CNTW-1:0]                              words_done
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int unsigned CW  = NSAMP * SW;

  state_e              state;
  trig_mode_e          mode_q;
  logic [CHW-1:0]      chan_q;
  logic signed [SW-1:0] lower_q, upper_q;
  logic [CNTW-1:0]     length_q, timeout_q, tcount;

  logic [CW-1:0] word;
  logic          any_below, any_above;
  logic [PW-1:0] below_idx, above_idx;
  logic          prime_hit, fire_hit, timeout_hit;
  logic [PW-1:0] fire_phase;
  logic          trig_now, trig_frc;
  logic [PW-1:0] trig_ph;

  always_comb begin
    word = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (chan_q == CHW'(c)) word = bus.samples[c*CW +: CW];
    end
  end

  sample_compare #(.NSAMP(NSAMP), .SW(SW), .PW(PW)) u_cmp (
    .word            (word),
    .lower           (lower_q),
    .upper           (upper_q),
    .any_below       (any_below),
    .any_above       (any_above),
    .first_below_idx (below_idx),
    .first_above_idx (above_idx)
  );

  // A genuine crossing in FIRE outranks a timeout landing on the same word.
  always_comb begin
    prime_hit  = 1'b0;
    fire_hit   = 1'b0;
    fire_phase = '0;
    case (mode_q)
      TRIG_RISING:   begin prime_hit = any_below; fire_hit = any_above; fire_phase = above_idx; end
      TRIG_FALLING:  begin prime_hit = any_above; fire_hit = any_below; fire_phase = below_idx; end
      TRIG_EXTERNAL: fire_hit = ext_trig;
      default:       ;
    endcase
    timeout_hit = (timeout_q != '0) && (tcount >= timeout_q);
    trig_now = 1'b0;
    trig_frc = 1'b0;
    trig_ph  = '0;
    if (bus.samples_valid) begin
      if (state == FIRE && fire_hit) begin
        trig_now = 1'b1;
        trig_ph  = fire_phase;
      end else if ((state == PRIME || state == FIRE) && timeout_hit) begin
        trig_now = 1'b1;
        trig_frc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= TRIG_IMMEDIATE;
      chan_q      <= '0;
      lower_q     <= '0;
      upper_q     <= '0;
      length_q    <= '0;
      timeout_q   <= '0;
      tcount      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      trig_phase  <= '0;
      trig_forced <= 1'b0;
      overflow    <= 1'b0;
      words_done  <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm) begin
            mode_q      <= trig_mode_e'(cfg_mode);
            chan_q      <= cfg_chan;
            lower_q     <= cfg_lower;
            upper_q     <= cfg_upper;
            length_q    <= cfg_length;
            timeout_q   <= cfg_timeout;
            tcount      <= '0;
            overflow    <= 1'b0;
            words_done  <= '0;
            trig_forced <= 1'b0;
            trig_phase  <= '0;
            if (cfg_length == '0) begin
              done <= 1'b1;
            end else begin
              busy <= 1'b1;
              case (trig_mode_e'(cfg_mode))
                TRIG_IMMEDIATE: state <= CAPTURE;
                TRIG_EXTERNAL:  state <= FIRE;
                default:        state <= PRIME;
              endcase
            end
          end
          PRIME, FIRE: begin
            if (tcount != '1) tcount <= tcount + CNTW'(1);
            if (trig_now) begin
              state       <= CAPTURE;
              trig_phase  <= trig_ph;
              trig_forced <= trig_frc;
              if (bus.fifo_full) begin
                overflow <= 1'b1;
              end else begin
                bus.wr_en   <= 1'b1;
                bus.wr_data <= bus.samples;
                words_done  <= words_done + CNTW'(1);
              end
            end else if (state == PRIME && bus.samples_valid && prime_hit) begin
              state <= FIRE;
            end
          end
          CAPTURE: begin
            if (words_done == length_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (bus.samples_valid) begin
              if (bus.fifo_full) begin
                overflow <= 1'b1;
              end else begin
                bus.wr_en   <= 1'b1;
                bus.wr_data <= bus.samples;
                words_done  <= words_done + CNTW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/trigger_engine.md
# trigger_engine

Parametrised acquisition/trigger engine for the ADC board: watches NCH channels of deserialised ADC sample words, arms on a host request, and detects a threshold crossing in rising or falling mode with sub-word phase reporting, an auto-trigger timeout and an external trigger. On trigger it streams a programmed number of sample words into the downstream capture FIFO, stalling instead of aborting when the FIFO is full. It sits between the LVDS deserialiser outputs and the capture FIFO write port, configured by the command processor.

## Interface
- NCH, 1: number of ADC channels carried on `samples`
- NSAMP, 10: samples per channel per clock word
- SW, 12: sample width, two's complement
- CNTW, 16: width of length, timeout and count fields
- `clk` in 1: sample clock (LVDS word clock); single clock domain
- `rst` in 1: asynchronous, active-high reset
- `samples` in NCH*NSAMP*SW: channel c, sample j at [(c*NSAMP+j)*SW +: SW]; sample 0 oldest
- `samples_valid` in 1: `samples` holds a new word this cycle
- `arm` in 1: single-cycle request to start an acquisition; config is latched on this cycle
- `abort` in 1: return to IDLE immediately, no `done`
- `cfg_mode` in 2: 0 immediate, 1 rising, 2 falling, 3 external
- `cfg_chan` in max(1,$clog2(NCH)): trigger source channel
- `cfg_lower`, `cfg_upper` in SW: signed thresholds
- `cfg_length` in CNTW: words to capture
- `cfg_timeout` in CNTW: armed cycles before auto-trigger; 0 = never
- `ext_trig` in 1: external trigger, level-sampled
- `fifo_full` in 1: capture FIFO full
- `wr_en` out 1: FIFO write strobe
- `wr_data` out NCH*NSAMP*SW: registered copy of `samples`
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse at capture completion
- `trig_phase` out $clog2(NSAMP): index of first qualifying sample in the triggering word
- `trig_forced` out 1: last trigger came from timeout
- `overflow` out 1: sticky, a valid word was dropped during capture due to `fifo_full`; cleared on `arm`
- `words_done` out CNTW: words written in the current/last capture

## Operation
- States: IDLE, PRIME, FIRE, CAPTURE.
- IDLE: `arm` latches all cfg_*, clears `overflow`, `words_done`, `trig_forced`, `trig_phase`, and the timeout counter. Mode 0 goes to CAPTURE; modes 1/2 go to PRIME; mode 3 goes to FIRE.
- PRIME, rising mode: on a valid word where any sample of `cfg_chan` is < `cfg_lower`, go to FIRE.
- PRIME, falling mode: on a valid word where any sample is > `cfg_upper`, go to FIRE.
- FIRE: evaluated only on valid words strictly after the priming word.
  - Rising mode fires when any sample is > `cfg_upper`.
  - Falling mode fires when any sample is < `cfg_lower`.
  - External mode fires on `ext_trig`=1 with `samples_valid`.
  - `trig_phase` is the lowest qualifying index; it is 0 for immediate, external and forced triggers.
  - The triggering word is the first word captured.
- Timeout: counts every cycle in PRIME or FIRE. When it reaches `cfg_timeout` (nonzero), the engine forces a trigger on the next valid word and sets `trig_forced`.
- CAPTURE: each valid word with `fifo_full`=0 is written and increments `words_done`. A valid word arriving with `fifo_full`=1 is dropped and sets `overflow`; the engine stays in CAPTURE.
- When `words_done` reaches `cfg_length`, pulse `done` and go to IDLE. `cfg_length`=0 pulses `done` one cycle after arm and writes nothing.
- `arm` outside IDLE is ignored. `abort` has priority over all transitions in any state and clears `wr_en` the next cycle.
- Comparisons are signed, SW bits. Counters never wrap: the timeout counter saturates.

## Timing
- Reset values: `wr_en`, `busy`, `done`, `trig_forced`, `overflow` = 0; `wr_data`, `trig_phase`, `words_done` = 0; state IDLE.
- All outputs are registered. The word presented in cycle n with write qualified appears on `wr_data` with `wr_en`=1 in cycle n+1.
- Trigger decision is combinational on cycle n inputs, so the triggering word is written at n+1.
- `busy` rises the cycle after `arm`. `done` and `busy` falling coincide with the cycle after the final `wr_en`.
- `fifo_full` is sampled in the same cycle as `samples_valid`. The FIFO must assert full with at least one word of slack.

## Structure
- Package `trigger_pkg`: mode encodings (TRIG_IMMEDIATE/RISING/FALLING/EXTERNAL), state enum, and a `first_set` index function.
- Sub-module `sample_compare`: per-channel-word, NSAMP parallel signed compares against lower/upper. Outputs any_below, any_above, first_below_idx, first_above_idx. Purely combinational.
- FSM, counters and output registers live in `trigger_engine`.

## Test plan
- Mode 0, length 5, continuous valid: 5 `wr_en` pulses starting 1 cycle after the first post-arm word; `done` pulses once; `words_done`=5.
- Rising, lower=-10, upper=10, NSAMP=10:
  - Word with sample 3 = -20, then word with samples 0..6 = 0 and 7 = 50: trigger on the second word, `trig_phase`=7, that word is first written.
  - A single word containing both -20 and +50 does not trigger.
- Falling, thresholds as above: +50 word then a word whose first negative-below sample is at index 2 → `trig_phase`=2.
- Timeout 100, flat zero input: forced trigger on the first valid word after 100 armed cycles; `trig_forced`=1.
- Capture length 8 with `fifo_full` held for 3 valid words mid-capture: `overflow`=1, exactly 8 writes, `done` delayed by 3 words.
- Asserting `abort` in FIRE and in CAPTURE returns to IDLE with no `done`. Async `rst` mid-capture drops `wr_en` immediately, all outputs go to reset values, and a fresh `arm` works.
